// File: rtl/fm_pkg.sv
// Shared constants and width helpers for the floating-point multiplier back end.
// Rounding-mode encodings and exponent/product width helpers live here.
package fm_pkg;

    localparam logic RM_RNE = 1'b0;
    localparam logic RM_RTZ = 1'b1;

    function automatic int prod_w(input int man_w);
        return 2 * man_w + 2;
    endfunction

    function automatic int exp_all_ones(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    function automatic int exp_max_finite(input int exp_w);
        return (1 << exp_w) - 2;
    endfunction

endpackage

// File: rtl/fm_lzc.sv
// Combinational leading-zero counter; count equals W when the input is all zeros.
module fm_lzc #(
    parameter int W  = 48,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count,
    output logic          all_zero
);

    // Ascending scan: the highest set bit is the last one to write the count.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) count = CW'(W - 1 - i);
        end
    end

    assign all_zero = ~|din;

endmodule

// File: rtl/fm_norm_round.sv
// Normalise / round / pack stage closing the FP multiplier pipeline.
// Two register stages (normalise, then round+classify) with valid/ready flow control.
module fm_norm_round
    import fm_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sign,
    input  logic [EXP_W+1:0]              in_exp,
    input  logic [prod_w(MAN_W)-1:0]      in_prod,
    input  logic                          in_rm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [EXP_W+MAN_W:0]          result,
    output logic                          flag_ovf,
    output logic                          flag_unf,
    output logic                          flag_inx
);

    localparam int PROD_W = prod_w(MAN_W);
    localparam int LZC_W  = $clog2(PROD_W + 1);
    localparam int EW     = EXP_W + 3;
    localparam int RES_W  = 1 + EXP_W + MAN_W;

    logic              v1, v2, adv1, adv2;
    logic [LZC_W-1:0]  lz;
    logic              prod_zero;
    logic [EW-1:0]     e1_c;
    logic [PROD_W-1:0] norm_c;

    logic              s1_sign, s1_rm, s1_zero;
    logic [EW-1:0]     s1_e1;
    logic [PROD_W-1:0] s1_prod;

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;

    fm_lzc #(.W(PROD_W), .CW(LZC_W)) u_lzc (
        .din      (in_prod),
        .count    (lz),
        .all_zero (prod_zero)
    );

    // Sign-extend the exponent so e1 cannot wrap for any lz.
    assign e1_c   = {in_exp[EXP_W+1], in_exp} + EW'(1) - EW'(lz);
    assign norm_c = in_prod << lz;

    // Stage 2 rounding on the registered, normalised product.
    logic [MAN_W:0]   kept, kept_inc;
    logic             g, sticky, round_up, carry, ovf, unf;
    logic [EW-1:0]    e2;
    logic [MAN_W-1:0] man2;
    logic [RES_W-1:0] res_c;
    logic             ovf_c, unf_c, inx_c;

    assign kept     = s1_prod[PROD_W-1 -: MAN_W+1];
    assign g        = s1_prod[PROD_W-2-MAN_W];
    assign sticky   = |s1_prod[PROD_W-3-MAN_W:0];
    assign round_up = (s1_rm == RM_RNE) && g && (sticky || kept[0]);
    assign {carry, kept_inc} = {1'b0, kept} + (MAN_W+2)'(round_up);
    assign e2       = carry ? s1_e1 + EW'(1) : s1_e1;
    assign man2     = carry ? '0 : kept_inc[MAN_W-1:0];
    assign ovf      = $signed(e2) >= $signed(EW'(exp_all_ones(EXP_W)));
    assign unf      = e2[EW-1] || (e2 == '0);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        res_c = {s1_sign, EXP_W'(0), MAN_W'(0)};
        ovf_c = 1'b0;
        unf_c = 1'b0;
        inx_c = 1'b0;
        if (s1_zero) begin
            res_c = {s1_sign, EXP_W'(0), MAN_W'(0)};
        end else if (ovf) begin
            ovf_c = 1'b1;
            inx_c = 1'b1;
            if (s1_rm == RM_RTZ)
                res_c = {s1_sign, EXP_W'(exp_max_finite(EXP_W)), {MAN_W{1'b1}}};
            else
                res_c = {s1_sign, {EXP_W{1'b1}}, MAN_W'(0)};
        end else if (unf) begin
            unf_c = 1'b1;
            inx_c = 1'b1;
        end else begin
            res_c = {s1_sign, e2[EXP_W-1:0], man2};
            inx_c = g || sticky;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            result   <= '0;
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_inx <= 1'b0;
        end else begin
            if (adv1) v1 <= in_valid;
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    result   <= res_c;
                    flag_ovf <= ovf_c;
                    flag_unf <= unf_c;
                    flag_inx <= inx_c;
                end
            end
        end
    end

    // NOTE: stage-1 payload is not reset; it is only ever consumed behind v1.
    always_ff @(posedge CLK) begin
        if (adv1 && in_valid) begin
            s1_sign <= in_sign;
            s1_rm   <= in_rm;
            s1_zero <= prod_zero;
            s1_e1   <= e1_c;
            s1_prod <= norm_c;
        end
    end

endmodule

// File: tb/tb_fm_norm_round.sv
// Self-checking bench for fm_norm_round: directed corner cases, random streams with
// random backpressure against an arithmetic reference model, and mid-flight reset.
module tb_fm_norm_round;

    logic        CLK, RESET;
    logic        in_valid, in_ready, in_sign, in_rm;
    logic [9:0]  in_exp;
    logic [47:0] in_prod;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        flag_ovf, flag_unf, flag_inx;

    fm_norm_round #(.EXP_W(8), .MAN_W(23)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_prod   (in_prod),
        .in_rm     (in_rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
        .flag_inx  (flag_inx)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          edge_cnt = 0;
    int          pop_edge = 0;
    logic        popped, accepted, hold_vld;
    logic [34:0] held, cur_exp;
    logic [34:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Reference: round the significand as a value against half an ulp; flags {ovf,unf,inx}.
    function automatic logic [34:0] ref_model(input logic sg, input int e_in,
                                              input logic [47:0] prod, input logic rm);
        longint unsigned kept, rem, half;
        int p, e, sh;
        logic inx, rnd;
        if (prod == '0) return {sg, 31'd0, 3'b000};
        p = 0;
        for (int i = 0; i < 48; i++) if (prod[i]) p = i;
        e = e_in + p - 46;
        if (p >= 23) begin
            sh   = p - 23;
            kept = 64'(prod) >> sh;
            rem  = 64'(prod) & ((64'd1 << sh) - 64'd1);
            half = (sh == 0) ? 64'd0 : (64'd1 << (sh - 1));
        end else begin
            kept = 64'(prod) << (23 - p);
            rem  = 64'd0;
            half = 64'd0;
        end
        inx = (rem != 64'd0);
        rnd = inx && ((rem > half) || (rem == half && kept[0]));
        if (!rm && rnd) kept++;
        if (kept == (64'd1 << 24)) begin
            kept = 64'd1 << 23;
            e++;
        end
        if (e >= 255) return rm ? {sg, 8'hFE, 23'h7FFFFF, 3'b101} : {sg, 8'hFF, 23'h0, 3'b101};
        if (e <= 0) return {sg, 31'd0, 3'b011};
        return {sg, 8'(e), kept[22:0], 2'b00, inx};
    endfunction

    // One clock: sample handshakes at the falling edge, then step past the rising edge.
    task automatic tick();
        logic [34:0] e;
        @(negedge CLK);
        popped   = 1'b0;
        accepted = 1'b0;
        if (RESET) begin
            exp_q.delete();
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'({result, flag_ovf, flag_unf, flag_inx}), 64'(held));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                accepted = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(exp_q.size() != 0), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'({result, flag_ovf, flag_unf, flag_inx}), 64'(e));
                    popped   = 1'b1;
                    pop_edge = edge_cnt;
                end
            end
            hold_vld = out_valid && !out_ready;
            held     = {result, flag_ovf, flag_unf, flag_inx};
        end
        @(posedge CLK);
        #1;
        edge_cnt++;
    endtask

    task automatic directed(input string tag, input logic sg, input int e, input logic [47:0] p,
                            input logic rm, input logic [34:0] expv);
        int start;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sign   = sg;
        in_exp    = e[9:0];
        in_prod   = p;
        in_rm     = rm;
        cur_exp   = expv;
        start     = edge_cnt;
        tick();
        in_valid = 1'b0;
        while (!popped && (edge_cnt - start) < 20) tick();
        check({tag, "_latency"}, 64'(popped ? pop_edge - start : -1), 64'd2);
    endtask

    task automatic rand_beat();
        int e;
        logic [47:0] p;
        e = int'($urandom_range(0, 380)) - 60;
        p = 48'({$urandom(), $urandom()}) >> $urandom_range(0, 47);
        if ($urandom_range(0, 15) == 0) p = '0;
        in_sign = 1'($urandom_range(0, 1));
        in_rm   = 1'($urandom_range(0, 1));
        in_exp  = e[9:0];
        in_prod = p;
        cur_exp = ref_model(in_sign, e, p, in_rm);
    endtask

    task automatic stream(input int n, input bit rand_rdy);
        int stalls = 0;
        for (int b = 0; b < n; b++) begin
            if (rand_rdy && $urandom_range(0, 3) == 0) begin
                in_valid  = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            rand_beat();
            in_valid = 1'b1;
            for (int g = 0; g < 200; g++) begin
                out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                tick();
                if (accepted) break;
                stalls++;
            end
            if (!accepted) check("accept_timeout", 64'(accepted), 64'd1);
        end
        in_valid = 1'b0;
        if (!rand_rdy) check("throughput_stalls", 64'(stalls), 64'd0);
    endtask

    task automatic drain();
        int guard = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && guard < 500) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = '0; in_prod = '0; in_rm = 1'b0;
        cur_exp = '0; held = '0; hold_vld = 1'b0; popped = 1'b0; accepted = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'({flag_ovf, flag_unf, flag_inx}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        RESET = 1'b0;

        directed("one",       1'b0, 127, 48'd1 << 46,                         1'b0, {32'h3F800000, 3'b000});
        directed("sq15",      1'b0, 127, (48'd1 << 47) | (48'd1 << 44),       1'b0, {32'h40100000, 3'b000});
        directed("sq15_min",  1'b0, 0,   (48'd1 << 47) | (48'd1 << 44),       1'b0, {32'h00900000, 3'b000});
        directed("tie_even",  1'b0, 127, (48'd1 << 46) | (48'd1 << 22),       1'b0, {32'h3F800000, 3'b001});
        directed("tie_odd",   1'b0, 127, (48'd3 << 22) | (48'd1 << 46),       1'b0, {32'h3F800002, 3'b001});
        directed("tie_rtz",   1'b0, 127, (48'd3 << 22) | (48'd1 << 46),       1'b1, {32'h3F800001, 3'b001});
        directed("carry",     1'b0, 127, ((48'd1 << 25) - 48'd1) << 22,       1'b0, {32'h40000000, 3'b001});
        directed("ovf_rne",   1'b0, 254, 48'd1 << 47,                         1'b0, {32'h7F800000, 3'b101});
        directed("ovf_rtz",   1'b0, 254, 48'd1 << 47,                         1'b1, {32'h7F7FFFFF, 3'b101});
        directed("unf",       1'b0, -5,  48'd1 << 46,                         1'b0, {32'h00000000, 3'b011});
        directed("zero_neg",  1'b1, 127, 48'd0,                               1'b0, {32'h80000000, 3'b000});

        stream(20, 1'b0);
        drain();
        stream(80, 1'b1);
        drain();

        // Fill both stages behind a stalled consumer, then reset with a beat offered.
        out_ready = 1'b0;
        rand_beat(); in_valid = 1'b1; tick();
        rand_beat(); tick();
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        rand_beat();
        RESET = 1'b1;
        tick();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result", 64'({result, flag_ovf, flag_unf, flag_inx}), 64'd0);
        RESET = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("postrst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("postrst_out_valid", 64'(out_valid), 64'd0);
        end

        stream(40, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
